call_stack_ctrl: RTL and testbench

- Return-address stack controller for the pat core's call/return sequencing.
- Captures the return address on call instructions and presents a registered top-of-stack as ret_adr to program_counter for return instructions.
- Tracks depth, detects overflow and underflow, and locks into a fault state on misuse until software or the host clears it.
- Sits beside the PC logic; op_call and op_return are driven by the core's decode.

---
 rtl/call_stack_ctrl.sv | 111 +++++++++++
 tb/tb_call_stack_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/call_stack_ctrl.sv
// Return-address stack for call/return sequencing.
// Registered top-of-stack, depth tracking, sticky errors and FAULT lock.
module call_stack_ctrl #(
  parameter int i_adr_width             = 10,
  parameter int call_stack_size         = 8,
  parameter int call_stack_pointer_size = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             op_call,
  input  logic                             op_return,
  input  logic [i_adr_width-1:0]           push_adr,
  input  logic                             err_clr,
  output logic [i_adr_width-1:0]           ret_adr,
  output logic [call_stack_pointer_size:0] depth,
  output logic                             empty,
  output logic                             full,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             fault
);

  localparam int PW = call_stack_pointer_size;
  localparam logic [PW:0] FULL_D = (PW+1)'(call_stack_size);

  typedef enum logic {RUN, FAULT} state_t;

  state_t state_q, state_d;

  logic [i_adr_width-1:0] stack [call_stack_size];
  logic [PW:0] dm1, dm2;

  logic active;
  logic push_en, repl_en, pop_en;
  logic ovf_ev, unf_ev;

  assign empty = (depth == '0);
  assign full  = (depth == FULL_D);
  assign fault = (state_q == FAULT);

  assign dm1 = depth - 1'b1;
  assign dm2 = depth - 2'd2;

  always_comb begin
    active  = 1'b0;
    push_en = 1'b0;
    repl_en = 1'b0;
    pop_en  = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    state_d = state_q;
    active  = (state_q == RUN) && !err_clr;
    // A combined call+return on an empty stack degrades to a plain push.
    unique case (1'b1)
      (op_call && !op_return): begin
        push_en = active && !full;
        ovf_ev  = active && full;
      end
      (op_call && op_return): begin
        push_en = active && empty;
        repl_en = active && !empty;
      end
      (!op_call && op_return): begin
        pop_en = active && !empty;
        unf_ev = active && empty;
      end
      default: ;
    endcase
    if (err_clr)
      state_d = RUN;
    else if (ovf_ev || unf_ev)
      state_d = FAULT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      depth     <= '0;
      ret_adr   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (ovf_ev) overflow  <= 1'b1;
        if (unf_ev) underflow <= 1'b1;
      end
      if (push_en) begin
        depth   <= depth + 1'b1;
        ret_adr <= push_adr;
      end else if (repl_en) begin
        ret_adr <= push_adr;
      end else if (pop_en) begin
        depth   <= dm1;
        ret_adr <= (depth >= 2) ? stack[dm2[PW-1:0]] : '0;
      end
    end
  end

  // Storage carries no reset; depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en)
      stack[depth[PW-1:0]] <= push_adr;
    else if (repl_en)
      stack[dm1[PW-1:0]] <= push_adr;
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: queue-based model compared every negedge,
// plus directed literal checks.
module tb_call_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_call = 1'b0;
  logic       op_return = 1'b0;
  logic [9:0] push_adr = '0;
  logic       err_clr = 1'b0;
  logic [9:0] ret_adr;
  logic [3:0] depth;
  logic       empty, full, overflow, underflow, fault;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  call_stack_ctrl dut (
    .clk(clk), .reset(reset), .op_call(op_call), .op_return(op_return),
    .push_adr(push_adr), .err_clr(err_clr), .ret_adr(ret_adr),
    .depth(depth), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [9:0] stk[$];
  bit m_ovf, m_unf, m_fault;

  function automatic logic [9:0] m_top();
    return (stk.size() == 0) ? 10'd0 : stk[$];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk.delete();
      m_ovf = 0; m_unf = 0; m_fault = 0;
    end else if (err_clr) begin
      m_ovf = 0; m_unf = 0; m_fault = 0;
    end else if (!m_fault) begin
      if (op_call && op_return) begin
        if (stk.size() == 0) stk.push_back(push_adr);
        else stk[stk.size()-1] = push_adr;
      end else if (op_call) begin
        if (stk.size() == 8) begin m_ovf = 1; m_fault = 1; end
        else stk.push_back(push_adr);
      end else if (op_return) begin
        if (stk.size() == 0) begin m_unf = 1; m_fault = 1; end
        else void'(stk.pop_back());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_depth", 32'(depth), 32'(stk.size()));
      chk("m_ret", 32'(ret_adr), 32'(m_top()));
      chk("m_empty", 32'(empty), 32'(stk.size() == 0));
      chk("m_full", 32'(full), 32'(stk.size() == 8));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_unf", 32'(underflow), 32'(m_unf));
      chk("m_fault", 32'(fault), 32'(m_fault));
    end
  end

  task automatic cyc(input bit c, input bit r, input logic [9:0] a,
                     input bit e);
    op_call = c; op_return = r; push_adr = a; err_clr = e;
    @(posedge clk);
    #2;
    op_call = 0; op_return = 0; push_adr = '0; err_clr = 0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #13 reset = 1'b1;
    @(posedge clk); #2;
    cmp_en = 1'b1;
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_fault", 32'(fault), 0);

    cyc(1, 0, 10'h005, 0);
    chk("p1_depth", 32'(depth), 1);
    chk("p1_ret", 32'(ret_adr), 32'h005);
    chk("p1_empty", 32'(empty), 0);
    cyc(0, 1, 0, 0);
    chk("pop1_ret", 32'(ret_adr), 0);
    chk("pop1_empty", 32'(empty), 1);

    cyc(1, 0, 10'h010, 0);
    cyc(1, 0, 10'h020, 0);
    cyc(1, 0, 10'h030, 0);
    chk("lifo_a", 32'(ret_adr), 32'h030);
    cyc(0, 1, 0, 0);
    chk("lifo_b", 32'(ret_adr), 32'h020);
    cyc(0, 1, 0, 0);
    chk("lifo_c", 32'(ret_adr), 32'h010);
    cyc(0, 1, 0, 0);
    chk("lifo_depth", 32'(depth), 0);

    for (int i = 0; i < 8; i++) cyc(1, 0, 10'(32'h100 + i), 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_ret", 32'(ret_adr), 32'h107);
    cyc(1, 0, 10'h3FF, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_depth", 32'(depth), 8);
    chk("ovf_ret", 32'(ret_adr), 32'h107);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("flt_hold", 32'(depth), 8);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_fault", 32'(fault), 0);
    for (int i = 7; i >= 0; i--) begin
      chk("drain_ret", 32'(ret_adr), 32'h100 + i);
      cyc(0, 1, 0, 0);
    end
    chk("drain_depth", 32'(depth), 0);

    cyc(0, 1, 0, 0);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_fault", 32'(fault), 1);
    cyc(1, 0, 10'h0AA, 1);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_ign", 32'(depth), 0);
    chk("clr_run", 32'(fault), 0);

    cyc(1, 1, 10'h155, 0);
    chk("cr_empty_depth", 32'(depth), 1);
    chk("cr_empty_ovf", 32'(overflow), 0);
    cyc(0, 1, 0, 0);

    cyc(1, 0, 10'h011, 0);
    cyc(1, 0, 10'h022, 0);
    cyc(1, 1, 10'h033, 0);
    chk("tail_depth", 32'(depth), 2);
    chk("tail_ret", 32'(ret_adr), 32'h033);
    cyc(0, 1, 0, 0);
    chk("tail_pop", 32'(ret_adr), 32'h011);
    cyc(0, 0, 0, 1);
    chk("clr_run_only", 32'(depth), 1);

    cyc(1, 0, 10'h044, 0);
    cyc(1, 0, 10'h055, 0);
    chk("pre_rst_depth", 32'(depth), 3);
    #1 reset = 1'b0;
    #1;
    chk("arst_depth", 32'(depth), 0);
    chk("arst_ret", 32'(ret_adr), 0);
    chk("arst_empty", 32'(empty), 1);
    reset = 1'b1;
    @(posedge clk); #2;
    cyc(0, 1, 0, 0);
    chk("post_rst_unf", 32'(underflow), 1);
    cyc(0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
